// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back sequencer.
package wb_pkg;

  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned WB_XLEN  = 32;
  localparam logic [4:0]  X0       = 5'd0;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  // Which source loads the write-back register this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO
  } wb_src_e;

  // A pending destination matches any decode query; x0 never matches.
  function automatic logic rd_hit(input logic [4:0] rd,
                                  input logic [4:0] rs1,
                                  input logic [4:0] rs2,
                                  input logic [4:0] rdq);
    return (rd != X0) && ((rd == rs1) || (rd == rs2) || (rd == rdq));
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Bus bundle between decode/execute/load units and the write-back sequencer.
interface wb_queue_if
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = WB_XLEN
) ();

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [4:0]      q_rd;
  logic            hazard;

  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  // Pipeline side: presents results and queries, sees the register-file port.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output q_rs1, q_rs2, q_rd,
    input  hazard,
    input  wb_we, wb_addr, wb_data
  );

  // Sequencer side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  q_rs1, q_rs2, q_rd,
    output hazard,
    output wb_we, wb_addr, wb_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous load-result FIFO; exposes per-entry valid bits and rd fields
// so the top level can scoreboard pending destinations.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH   = WB_DEPTH,
  parameter type         entry_t = wb_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  entry_t               din,
  input  logic                 pop,
  output entry_t               dout,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count,
  output logic [DEPTH-1:0]     valid,
  output logic [DEPTH-1:0][4:0] rd_arr
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Storage array; contents need no reset because count gates every use.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    valid  = '0;
    rd_arr = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off       = AW'(i) - rptr;
      valid[i]  = ({1'b0, off} < count);
      rd_arr[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back sequencer: sole driver of the register-file write port.
// ALU results take priority; load results queue in wb_fifo.
// Optional statistics counters are built when WB_STATS_EN is defined.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned XLEN  = WB_XLEN,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  wb_queue_if.slave   bus
`ifdef WB_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] full_cnt
`endif
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t                 fifo_din;
  entry_t                 fifo_dout;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            fifo_count;
  logic [DEPTH-1:0]       fifo_valid;
  logic [DEPTH-1:0][4:0]  fifo_rd;

  logic                   ld_ready;
  logic                   alu_take;
  wb_src_e                src;
  logic                   hazard;
  logic                   wb_we;
  logic [4:0]             wb_addr;
  logic [XLEN-1:0]        wb_data;

  // Full slots are not credited by a same-cycle pop.
  assign ld_ready  = !fifo_full;
  assign alu_take  = bus.alu_valid && (bus.alu_rd != X0);
  // x0 loads complete the handshake but are dropped here.
  assign fifo_push = bus.ld_valid && ld_ready && (bus.ld_rd != X0);
  assign fifo_din  = '{rd: bus.ld_rd, data: bus.ld_data};
  assign fifo_pop  = (src == SRC_FIFO);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (fifo_push),
    .din    (fifo_din),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count),
    .valid  (fifo_valid),
    .rd_arr (fifo_rd)
  );

  // Port arbitration: ALU first, then the FIFO head (never the same-cycle push).
  always_comb begin
    src = SRC_NONE;
    if (alu_take)              src = SRC_ALU;
    else if (fifo_count != '0) src = SRC_FIFO;
  end

  // Registered register-file write port; address and data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      case (src)
        SRC_ALU: begin
          wb_we   <= 1'b1;
          wb_addr <= bus.alu_rd;
          wb_data <= bus.alu_data;
        end
        SRC_FIFO: begin
          wb_we   <= 1'b1;
          wb_addr <= fifo_dout.rd;
          wb_data <= fifo_dout.data;
        end
        default: wb_we <= 1'b0;
      endcase
    end
  end

  // Scoreboard: any live FIFO entry or the in-flight write matches a query.
  always_comb begin
    logic fifo_hit;
    fifo_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && rd_hit(fifo_rd[i], bus.q_rs1, bus.q_rs2, bus.q_rd))
        fifo_hit = 1'b1;
    end
    hazard = (!fifo_empty && fifo_hit) ||
             (wb_we && rd_hit(wb_addr, bus.q_rs1, bus.q_rs2, bus.q_rd));
  end

  assign bus.ld_ready = ld_ready;
  assign bus.hazard   = hazard;
  assign bus.wb_we    = wb_we;
  assign bus.wb_addr  = wb_addr;
  assign bus.wb_data  = wb_data;

`ifdef WB_STATS_EN
  // Saturating counters: loads starved by ALU writes, and back-pressured offers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      full_cnt  <= '0;
    end else begin
      if ((fifo_count != '0) && (src == SRC_ALU) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (bus.ld_valid && !ld_ready && (full_cnt != '1))
        full_cnt <= full_cnt + 1'b1;
    end
  end
`endif

endmodule
